// File: rtl/vga_mux_top.sv
// vga_mux_top: parametrised VGA timing with frame-synchronous source select.
// Ports: clk, rst (sync, active-high), sel, src_r/g/b (packed per source),
//   pix_x/pix_y/pix_visible (live coordinates), frame, active_sel,
//   hsync/vsync/r/g/b (registered, aligned to source latency).
module vga_mux_top #(
  parameter int H_VISIBLE        = 640,
  parameter int H_FRONT          = 16,
  parameter int H_SYNC           = 96,
  parameter int H_BACK           = 48,
  parameter int V_VISIBLE        = 480,
  parameter int V_FRONT          = 10,
  parameter int V_SYNC           = 2,
  parameter int V_BACK           = 33,
  parameter int SYNC_ACTIVE_HIGH = 0,
  parameter int COLOR_W          = 4,
  parameter int NUM_SOURCES      = 2,
  parameter int SRC_LATENCY      = 1,
  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
  localparam int X_W     = $clog2(H_TOTAL),
  localparam int Y_W     = $clog2(V_TOTAL),
  localparam int SEL_W   = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [SEL_W-1:0]               sel,
  input  logic [NUM_SOURCES*COLOR_W-1:0] src_r,
  input  logic [NUM_SOURCES*COLOR_W-1:0] src_g,
  input  logic [NUM_SOURCES*COLOR_W-1:0] src_b,
  output logic [X_W-1:0]                 pix_x,
  output logic [Y_W-1:0]                 pix_y,
  output logic                           pix_visible,
  output logic [31:0]                    frame,
  output logic [SEL_W-1:0]               active_sel,
  output logic                           hsync,
  output logic                           vsync,
  output logic [COLOR_W-1:0]             r,
  output logic [COLOR_W-1:0]             g,
  output logic [COLOR_W-1:0]             b
);

  // One spare bit so sync end bounds equal to the total still fit.
  localparam int XC = X_W + 1;
  localparam int YC = Y_W + 1;

  localparam logic [XC-1:0] H_LAST = XC'(H_TOTAL - 1);
  localparam logic [XC-1:0] H_VIS  = XC'(H_VISIBLE);
  localparam logic [XC-1:0] HS_BEG = XC'(H_VISIBLE + H_FRONT);
  localparam logic [XC-1:0] HS_END = XC'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [YC-1:0] V_LAST = YC'(V_TOTAL - 1);
  localparam logic [YC-1:0] V_VIS  = YC'(V_VISIBLE);
  localparam logic [YC-1:0] VS_BEG = YC'(V_VISIBLE + V_FRONT);
  localparam logic [YC-1:0] VS_END = YC'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic              SYNC_ON = (SYNC_ACTIVE_HIGH != 0);
  localparam logic [SEL_W:0]    N_SRC   = (SEL_W + 1)'(NUM_SOURCES);

  logic [X_W-1:0] h;
  logic [Y_W-1:0] v;
  logic [XC-1:0]  hx;
  logic [YC-1:0]  vx;
  logic           h_wrap;
  logic           v_wrap;
  logic           hs_now;
  logic           vs_now;

  assign hx     = {1'b0, h};
  assign vx     = {1'b0, v};
  assign h_wrap = (hx == H_LAST);
  assign v_wrap = (vx == V_LAST);

  assign pix_x       = h;
  assign pix_y       = v;
  assign pix_visible = (hx < H_VIS) && (vx < V_VIS);

  assign hs_now = ((hx >= HS_BEG) && (hx < HS_END)) ? SYNC_ON : ~SYNC_ON;
  assign vs_now = ((vx >= VS_BEG) && (vx < VS_END)) ? SYNC_ON : ~SYNC_ON;

  always_ff @(posedge clk) begin
    if (rst) begin
      h          <= '0;
      v          <= '0;
      frame      <= '0;
      active_sel <= '0;
    end else begin
      if (h_wrap) begin
        h <= '0;
        if (v_wrap) v <= '0;
        else        v <= v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
      if (h_wrap && v_wrap) begin
        frame <= frame + 32'd1;
        // Out-of-range requests keep the current source.
        if ({1'b0, sel} < N_SRC) active_sel <= sel;
      end
    end
  end

  logic             vis_d;
  logic             hs_d;
  logic             vs_d;
  logic [SEL_W-1:0] sel_d;

  if (SRC_LATENCY == 0) begin : g_direct
    assign vis_d = pix_visible;
    assign hs_d  = hs_now;
    assign vs_d  = vs_now;
    assign sel_d = active_sel;
  end else begin : g_pipe
    logic [SRC_LATENCY-1:0] vis_q;
    logic [SRC_LATENCY-1:0] hs_q;
    logic [SRC_LATENCY-1:0] vs_q;
    logic [SEL_W-1:0]       sel_q [SRC_LATENCY];

    always_ff @(posedge clk) begin
      if (rst) begin
        vis_q <= '0;
        hs_q  <= {SRC_LATENCY{~SYNC_ON}};
        vs_q  <= {SRC_LATENCY{~SYNC_ON}};
        for (int i = 0; i < SRC_LATENCY; i++) sel_q[i] <= '0;
      end else begin
        vis_q[0] <= pix_visible;
        hs_q[0]  <= hs_now;
        vs_q[0]  <= vs_now;
        sel_q[0] <= active_sel;
        for (int i = 1; i < SRC_LATENCY; i++) begin
          vis_q[i] <= vis_q[i-1];
          hs_q[i]  <= hs_q[i-1];
          vs_q[i]  <= vs_q[i-1];
          sel_q[i] <= sel_q[i-1];
        end
      end
    end

    assign vis_d = vis_q[SRC_LATENCY-1];
    assign hs_d  = hs_q[SRC_LATENCY-1];
    assign vs_d  = vs_q[SRC_LATENCY-1];
    assign sel_d = sel_q[SRC_LATENCY-1];
  end

  logic [COLOR_W-1:0] mux_r;
  logic [COLOR_W-1:0] mux_g;
  logic [COLOR_W-1:0] mux_b;

  // Select travels with its pixel, so a frame-wrap switch is tear-free.
  always_comb begin
    mux_r = '0;
    mux_g = '0;
    mux_b = '0;
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (sel_d == SEL_W'(i)) begin
        mux_r = src_r[i*COLOR_W +: COLOR_W];
        mux_g = src_g[i*COLOR_W +: COLOR_W];
        mux_b = src_b[i*COLOR_W +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r     <= '0;
      g     <= '0;
      b     <= '0;
      hsync <= ~SYNC_ON;
      vsync <= ~SYNC_ON;
    end else begin
      r     <= vis_d ? mux_r : '0;
      g     <= vis_d ? mux_g : '0;
      b     <= vis_d ? mux_b : '0;
      hsync <= hs_d;
      vsync <= vs_d;
    end
  end

endmodule

// File: doc/vga_mux_top.md
# vga_mux_top

Parametrised VGA top: generates configurable video timing, presents pixel coordinates to `NUM_SOURCES` image sources, selects one source per frame, and drives blanked, pipeline-aligned RGB plus sync outputs. This is the next-generation screensaver top. Timing, colour depth, source count and source latency are parameters, and source switching is frame-synchronous so a frame never tears.

## Interface
- `H_VISIBLE`, 640, visible pixels per line
- `H_FRONT`, 16; `H_SYNC`, 96; `H_BACK`, 48: horizontal porch and sync widths in clocks
- `V_VISIBLE`, 480, visible lines per frame
- `V_FRONT`, 10; `V_SYNC`, 2; `V_BACK`, 33: vertical porch and sync widths in lines
- `SYNC_ACTIVE_HIGH`, 0: 0 means sync pulses drive low; 1 means they drive high
- `COLOR_W`, 4, bits per colour channel
- `NUM_SOURCES`, 2, number of image sources (≥1)
- `SRC_LATENCY`, 1, clocks from coordinate presentation to valid source pixel (≥0)
- Derived values:
  - `H_TOTAL` is the sum of the four H widths; `V_TOTAL` is the sum of the four V widths.
  - `X_W = $clog2(H_TOTAL)`, `Y_W = $clog2(V_TOTAL)`, `SEL_W = max(1, $clog2(NUM_SOURCES))`.

- `clk`  in  1  pixel clock
- `rst`  in  1  synchronous, active-high reset
- `sel`  in  SEL_W  requested source index
- `src_r`, `src_g`, `src_b`  in  NUM_SOURCES*COLOR_W each  source pixels; source i occupies bits [i*COLOR_W +: COLOR_W]
- `pix_x`  out  X_W  current horizontal count
- `pix_y`  out  Y_W  current vertical count
- `pix_visible`  out  1  current count lies in the visible region
- `frame`  out  32  completed-frame counter
- `active_sel`  out  SEL_W  source used for the current frame
- `hsync`, `vsync`  out  1  sync outputs, polarity set by `SYNC_ACTIVE_HIGH`
- `r`, `g`, `b`  out  COLOR_W  output colour

## Operation
- **Counters.**
  - `h` runs 0..H_TOTAL-1 and wraps to 0.
  - `v` advances by 1 when `h` wraps, runs 0..V_TOTAL-1 and wraps to 0.
  - `frame` advances by 1 (modulo 2^32) when `h` and `v` wrap on the same clock.
- **Coordinates.** `pix_x`/`pix_y` equal `h`/`v` combinationally. `pix_visible = (h < H_VISIBLE) && (v < V_VISIBLE)`.
- **Sync.**
  - hsync is active while `H_VISIBLE+H_FRONT ≤ h < H_VISIBLE+H_FRONT+H_SYNC`.
  - vsync is active while `V_VISIBLE+V_FRONT ≤ v < V_VISIBLE+V_FRONT+V_SYNC`, for whole lines.
  - The inactive level is the complement of the active level.
- **Source select.**
  - `active_sel` loads `sel` only on the clock where `h==H_TOTAL-1` and `v==V_TOTAL-1`, so it takes effect from pixel (0,0) onward.
  - If `sel ≥ NUM_SOURCES` at that clock, `active_sel` holds its previous value.
  - `sel` changes at any other time have no effect.
- **Alignment pipeline.**
  - visible, hsync and vsync are delayed through `SRC_LATENCY` register stages, so they line up with source data.
  - The source is muxed by `active_sel`, also delayed `SRC_LATENCY` stages, so a select change cannot split a pixel from its data.
  - One final register stage then drives `r`, `g`, `b`, `hsync` and `vsync`.
  - When the delayed visible flag is 0, `r`/`g`/`b` are 0.

## Timing
- **Reset values.** On the clock with `rst=1`:
  - `h`, `v`, `frame` and `active_sel` become 0.
  - All pipeline stages clear to not-visible, sync-inactive.
  - On the next edge, `r`, `g`, `b` = 0 and `hsync`/`vsync` sit at their inactive level.
- **Reset mid-frame.** Reset restarts immediately at (0,0). Stale pipeline contents are discarded, never emitted.
- **Latency.** Counter state at clock t appears on `hsync`/`vsync`/`r`/`g`/`b` at clock t+SRC_LATENCY+1. With `SRC_LATENCY=0`, sources are sampled combinationally in the same cycle and the output is 1 clock after the coordinates.
- **Frame rollover.** The first output of a new frame appears SRC_LATENCY+1 clocks after `frame` increments.
- **Simultaneous events.** Line wrap, frame wrap, `frame` increment and `active_sel` load all happen on the same edge.
- **Counter width.** `frame` wraps 0xFFFFFFFF→0 with no flag.

## Test plan
Small timing for scenarios 1–4: H = 4/1/2/1 (H_TOTAL=8), V = 3/1/1/1 (V_TOTAL=6), so one frame is 48 clocks. Unless stated, COLOR_W=4, NUM_SOURCES=3, SRC_LATENCY=2.

1. **Reset and sync.** Hold rst for 3 clocks, then release.
   - Immediately after reset: r/g/b=0 and hsync=vsync=1 (active-low).
   - hsync goes low for exactly 2 clocks every 8, starting 8 clocks after release (h=5..6 plus 3 clocks of latency).
   - vsync goes low for 8 consecutive clocks once per 48-clock frame.
2. **Pixel alignment.** Source 0 returns r = pix_x and g = pix_y, delayed 2 clocks.
   - Output r equals the x that was presented 3 clocks earlier.
   - Blanked pixels are 0.
   - Exactly 12 non-zero-candidate pixels per frame.
3. **Frame-synchronous select.**
   - Change sel 0→2 at mid-frame (h=2, v=1). Output keeps source 0 until the first pixel of the next frame, then switches to source 2. `active_sel` changes on the frame-wrap edge.
   - Then drive sel=3 at a frame wrap. `active_sel` stays 2.
4. **Frame counter and mid-frame reset.**
   - After 5 frames, `frame`=5.
   - Assert rst at h=3, v=2. Next clock: `frame`=0, `pix_x`=0, `pix_y`=0, and no stale colour reaches the outputs.
5. **Defaults.** Run 640x480 timing with SRC_LATENCY=0 and SYNC_ACTIVE_HIGH=1.
   - Line period is 800 clocks; frame period is 420000 clocks.
   - hsync is high for 96 clocks per line; vsync is high for 2 lines per frame.
   - Output lags the coordinates by 1 clock.
